// File: rtl/host_mem_bridge_pkg.sv
// Shared types and constants for host_mem_bridge: FSM state encoding,
// statistics-counter address offsets and the supported SRAM read-latency range.
package host_mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Offsets below 2^ADDR_W of the read- and write-access counters
    localparam int STAT_RD_OFS = 1;
    localparam int STAT_WR_OFS = 2;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    function automatic int clamp_rd_lat(input int lat);
        if (lat < RD_LAT_MIN) return RD_LAT_MIN;
        if (lat > RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/host_mem_bridge_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over
// increment and the count sticks at all-ones.
module host_bridge_sat_cnt #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [DATA_W-1:0] count
);

    logic [DATA_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/host_mem_bridge.sv
// Host-bus to single-port synchronous SRAM bridge with out-of-range drop and
// sticky error flag. Define HOST_BRIDGE_STATS_EN to add read/write access counters.
module host_mem_bridge
    import host_mem_bridge_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 1024,
    parameter int RD_LAT    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            address,
    input  logic                         wvalid,
    input  logic [DATA_W-1:0]            wdata,
    output logic                         wready,
    input  logic                         rvalid,
    output logic                         rready,
    output logic                         rrvalid,
    output logic [DATA_W-1:0]            rdata,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         err_oob,
    input  logic                         err_clr
);

    localparam int MA_W  = $clog2(MEM_DEPTH);
    localparam int LAT   = clamp_rd_lat(RD_LAT);
    localparam int CNT_W = $clog2(RD_LAT_MAX);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  lat_cnt_reg;
    logic              rd_mem_reg;
    logic [DATA_W-1:0] fill_reg;
    logic              mem_en_reg, mem_we_reg;
    logic [MA_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              rrvalid_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_oob_reg;

    logic idle, wr_hs, rd_hs, any_hs, in_range, rd_done;
    logic              stat_hit;
    logic [DATA_W-1:0] stat_val;

    assign idle     = (state_reg == IDLE);
    assign wr_hs    = idle && wvalid;
    assign rd_hs    = idle && rvalid && !wvalid;
    assign any_hs   = wr_hs || rd_hs;
    // Full-width compare so high address bits never alias into the SRAM
    assign in_range = ({1'b0, address} < (ADDR_W + 1)'(MEM_DEPTH));
    // The SRAM enable cycle itself does not count toward the latency wait
    assign rd_done  = (state_reg == RD_WAIT) && !mem_en_reg && (lat_cnt_reg == '0);

`ifdef HOST_BRIDGE_STATS_EN
    localparam logic [ADDR_W-1:0] STAT_RD_ADDR = {ADDR_W{1'b1}} - ADDR_W'(STAT_RD_OFS - 1);
    localparam logic [ADDR_W-1:0] STAT_WR_ADDR = {ADDR_W{1'b1}} - ADDR_W'(STAT_WR_OFS - 1);

    logic [1:0]        stat_sel, stat_inc, stat_clr;
    logic [DATA_W-1:0] stat_cnt [2];

    // Index 0 counts reads, index 1 counts writes
    assign stat_sel = {address == STAT_WR_ADDR, address == STAT_RD_ADDR};
    assign stat_inc = {wr_hs && in_range, rd_hs && in_range};
    assign stat_clr = {2{wr_hs}} & stat_sel;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_stat
        host_bridge_sat_cnt #(.DATA_W(DATA_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (stat_inc[gi]),
            .clr   (stat_clr[gi]),
            .count (stat_cnt[gi])
        );
    end

    assign stat_hit = |stat_sel;
    assign stat_val = stat_sel[0] ? stat_cnt[0] : stat_cnt[1];
`else
    assign stat_hit = 1'b0;
    assign stat_val = '0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (wr_hs) state_next = WRITE;
                     else if (rd_hs) state_next = RD_WAIT;
            WRITE:   state_next = IDLE;
            RD_WAIT: if (rd_done) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lat_cnt_reg   <= '0;
            rd_mem_reg    <= 1'b0;
            fill_reg      <= '0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rrvalid_reg   <= 1'b0;
            rdata_reg     <= '0;
            err_oob_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mem_en_reg <= any_hs && in_range;
            mem_we_reg <= wr_hs && in_range;
            if (any_hs) begin
                mem_addr_reg <= address[MA_W-1:0];
                rd_mem_reg   <= in_range;
                fill_reg     <= stat_hit ? stat_val : '0;
                lat_cnt_reg  <= in_range ? CNT_W'(LAT - 1) : '0;
            end else if ((state_reg == RD_WAIT) && !mem_en_reg && (lat_cnt_reg != '0)) begin
                lat_cnt_reg <= lat_cnt_reg - 1'b1;
            end
            if (wr_hs) mem_wdata_reg <= wdata;
            rrvalid_reg <= rd_done;
            if (rd_done) rdata_reg <= rd_mem_reg ? mem_rdata : fill_reg;
            err_oob_reg <= (any_hs && !in_range && !stat_hit) || (err_oob_reg && !err_clr);
        end
    end

    // Gated by rst_n so the handshake outputs read 0 while reset is held
    assign wready    = rst_n && idle;
    assign rready    = rst_n && idle;
    assign rrvalid   = rrvalid_reg;
    assign rdata     = rdata_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign err_oob   = err_oob_reg;

endmodule
